ita_weight_buffer: RTL

ITA_WEIGHT_BUFFER -- requirements
Module: ita_weight_buffer

---
 rtl/ita_package.sv | 15 +
 rtl/ita_weight_buffer.sv | 105 ++++++++++
 2 files changed

// File: rtl/ita_package.sv
// ita_package
// Shared types and constants for the ITA datapath.
//   weight_t        : one weight tile, TILE_N signed elements of WEIGHT_W bits,
//                     as fed to the inp2 operand mux.
//   DEFAULT_REUSE_W : default width of the per-tile reuse counter.
package ita_package;

    localparam int unsigned WEIGHT_W        = 8;
    localparam int unsigned TILE_N          = 4;
    localparam int unsigned DEFAULT_REUSE_W = 16;

    typedef logic signed [WEIGHT_W-1:0] weight_elem_t;
    typedef weight_elem_t [TILE_N-1:0]  weight_t;

endpackage

// File: rtl/ita_weight_buffer.sv
// ita_weight_buffer
// Two-entry ping-pong buffer for weight tiles. Each tile is stored with a
// reuse length and stays at the head until it has been consumed that many
// times (calc_en_i cycles), then the next tile takes its place.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset (highest priority)
//   clear_i        : synchronous flush of all buffered tiles
//   weight_valid_i : upstream tile valid
//   weight_ready_o : buffer can accept a tile this cycle
//   weight_i       : incoming tile
//   reuse_len_i    : consume cycles for the incoming tile (0 behaves as 1)
//   calc_en_i      : downstream consumes the head tile this cycle
//   weight_valid_o : head tile present
//   weight_o       : head tile ('0 when empty)
//   last_use_o     : this consume cycle is the head tile's final one
//   occupancy_o    : number of stored tiles, 0..2
module ita_weight_buffer
    import ita_package::*;
#(
    parameter int unsigned REUSE_W = DEFAULT_REUSE_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               weight_valid_i,
    output logic               weight_ready_o,
    input  weight_t            weight_i,
    input  logic [REUSE_W-1:0] reuse_len_i,
    input  logic               calc_en_i,
    output logic               weight_valid_o,
    output weight_t            weight_o,
    output logic               last_use_o,
    output logic [1:0]         occupancy_o
);

    weight_t            r_mem [2];
    logic [REUSE_W-1:0] r_len [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_occ;
    logic [REUSE_W-1:0] r_use_cnt;

    logic               w_valid;
    logic               w_ready;
    logic               w_accept;
    logic               w_release;
    logic               w_consume;
    logic [REUSE_W-1:0] w_len_eff;

    // Ready depends only on registered occupancy, so a release while full
    // frees the slot for the next cycle, never the current one.
    assign w_valid   = (r_occ != 2'd0);
    assign w_ready   = (r_occ < 2'd2);
    assign w_accept  = weight_valid_i && w_ready;
    assign w_consume = w_valid && calc_en_i;

    // A stored length of 0 is treated as 1 so the tile still retires.
    assign w_len_eff = (r_len[r_rd_ptr] == '0) ? REUSE_W'(1) : r_len[r_rd_ptr];
    assign w_release = w_consume && (r_use_cnt == (w_len_eff - REUSE_W'(1)));

    assign weight_ready_o = w_ready;
    assign weight_valid_o = w_valid;
    assign last_use_o     = w_release;
    assign occupancy_o    = r_occ;
    assign weight_o       = w_valid ? r_mem[r_rd_ptr] : '0;

    // Control state: pointers, occupancy and use counter.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
            r_use_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end

            if (w_release) begin
                r_rd_ptr  <= ~r_rd_ptr;
                r_use_cnt <= '0;
            end else if (w_consume) begin
                r_use_cnt <= r_use_cnt + REUSE_W'(1);
            end

            case ({w_accept, w_release})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Tile storage carries no reset; an entry is only visible once
    // occupancy covers it, and reset/clear zero the occupancy.
    always_ff @(posedge clk_i) begin
        if (w_accept && !rst_i && !clear_i) begin
            r_mem[r_wr_ptr] <= weight_i;
            r_len[r_wr_ptr] <= reuse_len_i;
        end
    end

endmodule
